// File: rtl/coproc_pkg.sv
// Shared state encoding, default widths and result limits for the matrix-multiply coprocessor.
package coproc_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ACC_W    = 40;
    localparam int unsigned DEF_RESULT_W = 32;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_IDX_W    = 8;
    localparam int unsigned DEF_A_BASE   = 0;
    localparam int unsigned DEF_B_BASE   = 512;

    localparam logic [DEF_RESULT_W-1:0] RESULT_MAX = {1'b0, {(DEF_RESULT_W-1){1'b1}}};
    localparam logic [DEF_RESULT_W-1:0] RESULT_MIN = {1'b1, {(DEF_RESULT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MAC  = 3'd3,
        DONE = 3'd4
    } pe_state_e;

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with a registered result stage.
// DOT_PRODUCT_SATURATE_EN selects saturation of the result instead of truncation.
module mac_unit
    import coproc_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned RESULT_W = DEF_RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     ld,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic [RESULT_W-1:0]      result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic [RESULT_W-1:0]        result_c;

    assign prod = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // Overflow shows as disagreement among the bits above the result's sign bit.
    always_comb begin
        result_c = acc[RESULT_W-1:0];
`ifdef DOT_PRODUCT_SATURATE_EN
        if (!((&acc[ACC_W-1:RESULT_W-1]) || !(|acc[ACC_W-1:RESULT_W-1]))) begin
            result_c = acc[ACC_W-1] ? {1'b1, {(RESULT_W-1){1'b0}}}
                                    : {1'b0, {(RESULT_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (ld) begin
            result <= result_c;
        end
    end

endmodule

// File: rtl/dot_product_unit.sv
// Processing element computing one C[row][col] dot product over a shared, granted read port.
// DOT_PRODUCT_SATURATE_EN (in mac_unit) saturates o_Result instead of truncating it.
module dot_product_unit
    import coproc_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned RESULT_W = DEF_RESULT_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter int unsigned A_BASE   = DEF_A_BASE,
    parameter int unsigned B_BASE   = DEF_B_BASE
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    input  logic                i_Index_Valid,
    input  logic [IDX_W-1:0]    i_Row_Index,
    input  logic [IDX_W-1:0]    i_Column_Index,
    input  logic [IDX_W-1:0]    i_Dimension,
    output logic                o_Indexes_Received,
    output logic                o_Mem_Request,
    input  logic                i_Mem_Grant,
    output logic                o_Mem_Read,
    output logic [ADDR_W-1:0]   o_Mem_Address,
    input  logic [DATA_W-1:0]   i_Mem_Data,
    output logic [RESULT_W-1:0] o_Result,
    output logic                o_Result_Ready,
    input  logic                i_Result_Taken,
    output logic                o_Busy
);

    localparam int unsigned PROD_IW = 2 * IDX_W;

    pe_state_e         state;
    logic [IDX_W-1:0]  dim;
    logic [IDX_W-1:0]  k;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_op;
    logic              rd_b_first;

    logic [PROD_IW-1:0] row_x_n;
    logic [ADDR_W-1:0]  a_addr_init;
    logic [ADDR_W-1:0]  b_addr_init;
    logic               k_last;
    logic               acc_clr;
    logic               acc_en;
    logic               res_ld;

    assign row_x_n     = PROD_IW'(i_Row_Index) * PROD_IW'(i_Dimension);
    assign a_addr_init = ADDR_W'(A_BASE) + ADDR_W'(row_x_n);
    assign b_addr_init = ADDR_W'(B_BASE) + ADDR_W'(i_Column_Index);
    assign k_last      = (k + IDX_W'(1)) == dim;

    // A read is issued only when the arbiter grants the outstanding request this cycle.
    assign o_Mem_Read = o_Mem_Request & i_Mem_Grant;

    assign acc_clr = (state == IDLE) & i_Index_Valid;
    assign acc_en  = (state == MAC);
    assign res_ld  = (state == DONE) & ~o_Result_Ready;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state              <= IDLE;
            dim                <= '0;
            k                  <= '0;
            a_addr             <= '0;
            b_addr             <= '0;
            a_op               <= '0;
            rd_b_first         <= 1'b0;
            o_Indexes_Received <= 1'b0;
            o_Mem_Request      <= 1'b0;
            o_Mem_Address      <= '0;
            o_Result_Ready     <= 1'b0;
            o_Busy             <= 1'b0;
        end else begin
            o_Indexes_Received <= 1'b0;
            rd_b_first         <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Index_Valid) begin
                        dim                <= i_Dimension;
                        k                  <= '0;
                        a_addr             <= a_addr_init;
                        b_addr             <= b_addr_init;
                        o_Indexes_Received <= 1'b1;
                        o_Busy             <= 1'b1;
                        if (i_Dimension == '0) begin
                            state <= DONE;
                        end else begin
                            state         <= RD_A;
                            o_Mem_Request <= 1'b1;
                            o_Mem_Address <= a_addr_init;
                        end
                    end
                end
                RD_A: begin
                    if (i_Mem_Grant) begin
                        state         <= RD_B;
                        o_Mem_Address <= b_addr;
                        rd_b_first    <= 1'b1;
                    end
                end
                RD_B: begin
                    // Read data for A is only valid in the cycle right after its read.
                    if (rd_b_first) begin
                        a_op <= i_Mem_Data;
                    end
                    if (i_Mem_Grant) begin
                        state         <= MAC;
                        o_Mem_Request <= 1'b0;
                        o_Mem_Address <= '0;
                    end
                end
                MAC: begin
                    a_addr <= a_addr + ADDR_W'(1);
                    b_addr <= b_addr + ADDR_W'(dim);
                    k      <= k + IDX_W'(1);
                    if (k_last) begin
                        state <= DONE;
                    end else begin
                        state         <= RD_A;
                        o_Mem_Request <= 1'b1;
                        o_Mem_Address <= a_addr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    if (!o_Result_Ready) begin
                        o_Result_Ready <= 1'b1;
                    end else if (i_Result_Taken) begin
                        o_Result_Ready <= 1'b0;
                        o_Busy         <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mac_unit #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .RESULT_W (RESULT_W)
    ) u_mac (
        .clk    (i_Clock),
        .rst_n  (i_Reset_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .ld     (res_ld),
        .a      (a_op),
        .b      (i_Mem_Data),
        .result (o_Result)
    );

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed bench for dot_product_unit with a behavioural operand memory and read/result scoreboards.
module tb_dot_product_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [7:0]  dim;
    logic        ack;
    logic        req;
    logic        grant;
    logic        rd;
    logic [9:0]  addr;
    logic [15:0] mem_data;
    logic [31:0] result;
    logic        ready;
    logic        taken;
    logic        busy;

    logic [15:0] mem [1024];
    logic [31:0] addr_q [$];
    logic [31:0] res_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_left = 0;
    logic [9:0]  stall_addr = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd) mem_data <= mem[addr];
    end

    dot_product_unit dut (
        .i_Clock            (clk),
        .i_Reset_n          (rst_n),
        .i_Index_Valid      (valid),
        .i_Row_Index        (row),
        .i_Column_Index     (col),
        .i_Dimension        (dim),
        .o_Indexes_Received (ack),
        .o_Mem_Request      (req),
        .i_Mem_Grant        (grant),
        .o_Mem_Read         (rd),
        .o_Mem_Address      (addr),
        .i_Mem_Data         (mem_data),
        .o_Result           (result),
        .o_Result_Ready     (ready),
        .i_Result_Taken     (taken),
        .o_Busy             (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: decide grant, check any read against the scoreboard, advance past the edge.
    task automatic cycle();
        logic denied;
        logic [31:0] exp_addr;
        denied = 1'b0;
        if (stall_left > 0 && req && addr == stall_addr) begin
            grant  = 1'b0;
            denied = 1'b1;
            stall_left--;
        end else begin
            grant = 1'b1;
        end
        #1;
        if (denied) begin
            check("stall_no_read", 32'(rd), 32'd0);
            check("stall_addr_held", 32'(addr), 32'(stall_addr));
        end
        if (rd) begin
            n_cmp++;
            assert (addr_q.size() != 0) else begin
                n_err++;
                $error("FAIL extra_read: observed read at 0x%0h expected none", addr);
            end
            if (addr_q.size() != 0) begin
                exp_addr = addr_q.pop_front();
                check("read_addr", 32'(addr), exp_addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int r, input int c, input int n, input logic [31:0] exp);
        for (int kk = 0; kk < n; kk++) begin
            addr_q.push_back(32'((r * n + kk) % 1024));
            addr_q.push_back(32'((512 + kk * n + c) % 1024));
        end
        res_q.push_back(exp);
    endtask

    task automatic accept(input logic [7:0] r, input logic [7:0] c, input logic [7:0] n);
        row   = r;
        col   = c;
        dim   = n;
        valid = 1'b1;
        cycle();
        check("ack_pulse", 32'(ack), 32'd1);
        valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, input string tag);
        int cnt;
        logic [31:0] exp_res;
        cnt = 0;
        while (!ready && cnt < 200) begin
            cycle();
            cnt++;
            if (cnt == 1) check("ack_one_cycle", 32'(ack), 32'd0);
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        n_cmp++;
        assert (res_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_scoreboard: observed result 0x%08h expected none queued", tag, result);
        end
        if (res_q.size() != 0) begin
            exp_res = res_q.pop_front();
            check({tag, "_result"}, result, exp_res);
        end
        check({tag, "_reads_done"}, 32'(addr_q.size()), 32'd0);
    endtask

    task automatic release_result(input string tag);
        taken = 1'b1;
        cycle();
        taken = 1'b0;
        check({tag, "_ready_drop"}, 32'(ready), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic load_basic();
        mem[0]   = 16'd1; mem[1]   = 16'd2; mem[2]   = 16'd3; mem[3]   = 16'd4;
        mem[512] = 16'd5; mem[513] = 16'd6; mem[514] = 16'd7; mem[515] = 16'd8;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; row = '0; col = '0; dim = '0;
        grant = 1'b1; taken = 1'b0;
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_read", 32'(rd), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic job and hold-until-taken.
        load_basic();
        push_job(0, 1, 2, 32'd22);
        accept(8'd0, 8'd1, 8'd2);
        check("basic_busy", 32'(busy), 32'd1);
        wait_result(7, "basic");
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_result", result, 32'd22);
            check("hold_ready", 32'(ready), 32'd1);
        end
        release_result("basic");

        // Signed operands, with a request offered while busy.
        mem[0]   = 16'hFFFD;
        mem[512] = 16'd5;
        push_job(0, 0, 1, 32'hFFFF_FFF1);
        accept(8'd0, 8'd0, 8'd1);
        row = 8'd3; col = 8'd3; dim = 8'd1; valid = 1'b1;
        cycle();
        check("busy_no_ack_1", 32'(ack), 32'd0);
        cycle();
        check("busy_no_ack_2", 32'(ack), 32'd0);
        valid = 1'b0;
        wait_result(2, "signed");
        release_result("signed");

        // Grant denied three cycles while reading B.
        load_basic();
        push_job(0, 1, 2, 32'd22);
        stall_addr = 10'd513;
        stall_left = 3;
        accept(8'd0, 8'd1, 8'd2);
        wait_result(10, "stall");
        check("stall_consumed", 32'(stall_left), 32'd0);
        release_result("stall");

        // Overflow of the 32-bit result range.
        for (int i = 0; i < 16; i++) begin
            mem[i]       = 16'h8000;
            mem[512 + i] = 16'h8000;
        end
`ifdef DOT_PRODUCT_SATURATE_EN
        push_job(0, 0, 4, 32'h7FFF_FFFF);
`else
        push_job(0, 0, 4, 32'h0000_0000);
`endif
        accept(8'd0, 8'd0, 8'd4);
        wait_result(13, "overflow");
        release_result("overflow");

        // Zero-length job.
        push_job(3, 2, 0, 32'd0);
        accept(8'd3, 8'd2, 8'd0);
        wait_result(1, "n_zero");
        release_result("n_zero");

        // Taken and valid together while DONE.
        load_basic();
        push_job(0, 1, 2, 32'd22);
        accept(8'd0, 8'd1, 8'd2);
        wait_result(7, "tv_first");
        push_job(1, 1, 2, 32'd50);
        row = 8'd1; col = 8'd1; dim = 8'd2;
        valid = 1'b1; taken = 1'b1;
        cycle();
        taken = 1'b0;
        check("tv_no_ack_in_done", 32'(ack), 32'd0);
        check("tv_ready_drop", 32'(ready), 32'd0);
        cycle();
        check("tv_accept_next", 32'(ack), 32'd1);
        valid = 1'b0;
        wait_result(7, "tv_second");
        release_result("tv_second");

        // Reset while in MAC, then a fresh job.
        push_job(0, 1, 2, 32'd22);
        accept(8'd0, 8'd1, 8'd2);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_read", 32'(rd), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        addr_q.delete();
        res_q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_job(1, 0, 2, 32'd43);
        accept(8'd1, 8'd0, 8'd2);
        wait_result(7, "after_rst");
        release_result("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dot_product_unit.md
Name: dot_product_unit

Overview:
- Processing element directly downstream of the main control unit in the matrix-multiply coprocessor.
- The main control unit hands over one (row, column) index pair per job. This block computes C[row][col] = sum over k of A[row][k]*B[k][col].
- Operands are fetched from the shared operand memory through a granted single read port, and the result is returned to the main control unit with a ready/taken handshake.
- The main control unit instantiates P of these, one per bit of its index-ready vector.

Parameters:
- DATA_W, 16, signed operand width (two's complement).
- ACC_W, 40, internal accumulator width.
- RESULT_W, 32, width of o_Result.
- ADDR_W, 10, memory address width.
- IDX_W, 8, row/column/dimension index width.
- A_BASE, 0, word address of A[0][0]; A is row-major.
- B_BASE, 512, word address of B[0][0]; B is row-major.

Ports:
- i_Clock  in  1  rising-edge clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Index_Valid  in  1  index pair offered (this PE's bit of the main CU's index-ready vector).
- i_Row_Index  in  IDX_W  row of A.
- i_Column_Index  in  IDX_W  column of B.
- i_Dimension  in  IDX_W  N, the inner dimension, taken from the config word.
- o_Indexes_Received  out  1  one-cycle pulse: indexes latched.
- o_Mem_Request  out  1  read-port request.
- i_Mem_Grant  in  1  read port granted this cycle.
- o_Mem_Read  out  1  read issued this cycle.
- o_Mem_Address  out  ADDR_W  read address.
- i_Mem_Data  in  DATA_W  read data, valid the cycle after o_Mem_Read.
- o_Result  out  RESULT_W  dot product.
- o_Result_Ready  out  1  o_Result valid.
- i_Result_Taken  in  1  main CU has consumed the result.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All outputs are 0. The accumulator, k, and the address registers are cleared.
- States: IDLE, RD_A, RD_B, MAC, DONE.
- IDLE:
  - If i_Index_Valid is sampled high: latch row, col and N.
  - Pulse o_Indexes_Received for exactly 1 cycle.
  - Set acc=0, k=0, a_addr=A_BASE+row*N, b_addr=B_BASE+col.
  - Go to RD_A, or to DONE with result 0 if N==0.
- RD_A:
  - o_Mem_Request=1 and o_Mem_Address=a_addr.
  - If i_Mem_Grant: o_Mem_Read=1 and go to RD_B. Otherwise stay, with o_Mem_Read=0.
- RD_B:
  - o_Mem_Request=1, o_Mem_Address=b_addr, and capture i_Mem_Data as operand a.
  - If i_Mem_Grant: o_Mem_Read=1 and go to MAC. Otherwise stay; operand a is captured only in the first RD_B cycle.
- MAC:
  - o_Mem_Request=0.
  - Capture b and set acc += a*b (signed, full 2*DATA_W product, sign-extended to ACC_W).
  - a_addr+=1, b_addr+=N, k+=1.
  - If k+1==N: register the result and go to DONE. Otherwise go to RD_A.
- DONE:
  - o_Result_Ready=1 and o_Result is held stable.
  - On i_Result_Taken: o_Result_Ready drops on the next edge and the state goes to IDLE.
- Addresses wrap modulo 2^ADDR_W. There is no bounds check.
- Result: the low RESULT_W bits of acc (see the optional feature).
- Latency with continuous grant: o_Result_Ready rises 3N+1 cycles after the edge that samples i_Index_Valid. Each cycle of grant denial adds 1 cycle.
- i_Index_Valid outside IDLE is ignored and no ack is given. The main CU holds valid until it sees o_Indexes_Received.
- i_Result_Taken and i_Index_Valid high together in DONE: go to IDLE. The new job is accepted on the following cycle.
- i_Result_Taken outside DONE is ignored.
- Grant withdrawn mid-read: the address is held and no read is counted.

Optional Feature:
- Macro: DOT_PRODUCT_SATURATE_EN.
- Defined: o_Result saturates acc to the signed RESULT_W range (0x7FFFFFFF or 0x80000000 at the default width).
- Undefined: o_Result is the truncated low RESULT_W bits of acc.

Decomposition:
- Package coproc_pkg holds:
  - the state enum for IDLE, RD_A, RD_B, MAC, DONE;
  - DATA_W, ADDR_W, IDX_W, A_BASE and B_BASE defaults shared with the main CU;
  - the signed max/min RESULT_W constants.
- One sub-module, mac_unit, holds the signed multiply, the accumulate, the clear, and the saturate/truncate output stage.

Test Plan:
- Basic job: N=2, A=[[1,2],[3,4]] at 0..3, B=[[5,6],[7,8]] at 512..515, row=0, col=1.
  - o_Indexes_Received pulses 1 cycle.
  - Reads issued in order at 0, 513, 1, 515.
  - o_Result=22 with o_Result_Ready high 7 cycles after acceptance.
  - Result held until i_Result_Taken.
- Signed operands: N=1, A[0][0]=-3, B[0][0]=5 → o_Result=0xFFFFFFF1 (-15).
- Grant stall: basic job with i_Mem_Grant low for 3 cycles in RD_B.
  - Address stays at 513 and o_Mem_Read=0 during the stall.
  - Result is still 22; ready arrives at cycle 10.
- Overflow: N=4, all operands -32768.
  - With DOT_PRODUCT_SATURATE_EN: 0x7FFFFFFF.
  - Without it: 0x00000000.
- Reset mid-operation: assert i_Reset_n=0 in the MAC state.
  - All outputs 0 immediately.
  - After release, a new job yields the correct result.
- Edge cases:
  - N=0: no memory reads; o_Result=0 with ready high 1 cycle after acceptance.
  - i_Index_Valid while busy gets no ack.
  - Taken and valid together in DONE: the new job is accepted the next cycle.
